serial_word_loader: RTL

//  Upstream feeder for the 16-bit holding register. Deserialises a framed bit stream
//  (start pulse, then WIDTH bits qualified by serial_valid) into a parallel word.

---
 rtl/swl_pkg.sv | 13 +
 rtl/swl_shift_reg.sv | 36 +++
 rtl/serial_word_loader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/swl_pkg.sv
// Shared definitions for the serial word loader: FSM state encoding and default word width.
package swl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    LOAD  = 2'd3
  } swl_state_t;

  localparam int SWL_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/swl_shift_reg.sv
// Shadow register that collects serial bits; MSB_FIRST selects which end the first bit ends up at.
module swl_shift_reg #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] parallel_out
);

  logic [WIDTH-1:0] shadow;

  // Shifting in at the LSB walks the first bit up to the MSB after WIDTH shifts, and vice versa.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          shadow <= '0;
        else if (shift_en)
          shadow <= {shadow[WIDTH-2:0], serial_in};
      end
    end else begin : g_lsb_first
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)
          shadow <= '0;
        else if (shift_en)
          shadow <= {serial_in, shadow[WIDTH-1:1]};
      end
    end
  endgenerate

  assign parallel_out = shadow;

endmodule

// File: rtl/serial_word_loader.sv
// Deserialises a start-framed bit stream into a word and strobes it into the holding register.
// Optional even-parity check on a trailing bit is enabled by defining PARITY_CHECK_EN.
import swl_pkg::*;

module serial_word_loader #(
  parameter int WIDTH     = SWL_DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic [WIDTH-1:0] write_data,
  output logic             write_enable,
  output logic             busy,
  output logic             parity_err
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef PARITY_CHECK_EN
  localparam swl_state_t AFTER_DATA = PAR;
`else
  localparam swl_state_t AFTER_DATA = LOAD;
`endif

  swl_state_t       state, state_next;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
  logic             shift_en;
  logic             load_fire;
  logic [WIDTH-1:0] shadow;

`ifdef PARITY_CHECK_EN
  logic par_fail;
  logic parity_acc;
  logic parity_err_q;
`endif

  swl_shift_reg #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift_reg (
    .clk          (clk),
    .reset        (reset),
    .shift_en     (shift_en),
    .serial_in    (serial_in),
    .parallel_out (shadow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      write_data   <= '0;
      write_enable <= 1'b0;
    end else begin
      state        <= state_next;
      bit_cnt      <= bit_cnt_next;
      write_enable <= load_fire;
      if (load_fire)
        write_data <= shadow;
    end
  end

  // Abort takes priority everywhere except IDLE, including over the final bit and the LOAD strobe.
  always_comb begin
    state_next   = state;
    bit_cnt_next = bit_cnt;
    shift_en     = 1'b0;
    load_fire    = 1'b0;
`ifdef PARITY_CHECK_EN
    par_fail     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (serial_valid) begin
          shift_en     = 1'b1;
          bit_cnt_next = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT)
            state_next = AFTER_DATA;
        end
      end
`ifdef PARITY_CHECK_EN
      PAR: begin
        if (abort) begin
          state_next   = IDLE;
          bit_cnt_next = '0;
        end else if (serial_valid) begin
          bit_cnt_next = '0;
          if (serial_in == parity_acc) begin
            state_next = LOAD;
          end else begin
            state_next = IDLE;
            par_fail   = 1'b1;
          end
        end
      end
`endif
      LOAD: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
        load_fire    = !abort;
      end
      default: begin
        state_next   = IDLE;
        bit_cnt_next = '0;
      end
    endcase
  end

  assign busy = (state != IDLE);

`ifdef PARITY_CHECK_EN
  // Running XOR of the data bits equals the even-parity bit the sender must append.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_acc   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      if (state == IDLE)
        parity_acc <= 1'b0;
      else if (shift_en)
        parity_acc <= parity_acc ^ serial_in;
      if (par_fail)
        parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
